// File: rtl/rx_framer_if.sv
// rx_framer_if: bit stream, control and CPU FIFO-side signals of the receive framer.
// The master modport is the demodulator/CPU side. The slave modport is the framer.
`ifndef CH_IDX_W
`define CH_IDX_W 6
`endif
`ifndef PREAMBLE_MSB1
`define PREAMBLE_MSB1 8'hAA
`endif
`ifndef PREAMBLE_MSB0
`define PREAMBLE_MSB0 8'h55
`endif

interface rx_framer_if #(
  parameter int TIMEOUT_W = 16
);
  logic                 en;
  logic                 rx;
  logic                 rx_valid;
  logic                 rxstart;
  logic                 rxready;
  logic [`CH_IDX_W-1:0] ch_idx;
  logic [31:0]          aa;
  logic [5:0]           rx_len;
  logic [TIMEOUT_W-1:0] timeout;
  logic [7:0]           rxdata_out;
  logic                 rd_en;
  logic                 empty;
  logic                 crc_ok;
  logic                 aa_timeout;
  logic                 overflow;

  modport master (
    output en, rx, rx_valid, rxstart, ch_idx, aa, rx_len, timeout, rd_en,
    input  rxready, rxdata_out, empty, crc_ok, aa_timeout, overflow
  );

  modport slave (
    input  en, rx, rx_valid, rxstart, ch_idx, aa, rx_len, timeout, rd_en,
    output rxready, rxdata_out, empty, crc_ok, aa_timeout, overflow
  );
endinterface

// File: rtl/rx_framer.sv
// rx_framer: access-address search, dewhitening and CRC-24 check, with payload bytes written to a FWFT byte FIFO.
// Defining RX_PREAMBLE_CHK_EN makes the search also require the 8-bit preamble ahead of the access address.
`ifndef PREAMBLE_MSB1
`define PREAMBLE_MSB1 8'hAA
`endif
`ifndef PREAMBLE_MSB0
`define PREAMBLE_MSB0 8'h55
`endif

module rx_framer #(
  parameter int          FIFO_DEPTH_LOG2 = 6,
  parameter int          TIMEOUT_W       = 16,
  parameter logic [23:0] CRC_INIT        = 24'h555555
) (
  input  logic        clk,
  input  logic        rst,
  rx_framer_if.slave  bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
`ifdef RX_PREAMBLE_CHK_EN
  localparam int SR_W = 40;
`else
  localparam int SR_W = 32;
`endif

  typedef enum logic [2:0] {IDLE, SEARCH, DATA, CRC, DONE} state_t;
  state_t r_state, w_state_nxt;

  logic                       r_rxstart;
  logic [SR_W-2:0]            r_sr;
  logic [TIMEOUT_W-1:0]       r_tcnt;
  logic [6:0]                 r_wlfsr;
  logic [23:0]                r_crc;
  logic [22:0]                r_cmp;
  logic [6:0]                 r_byte;
  logic [4:0]                 r_bitcnt;
  logic [5:0]                 r_bytecnt;
  logic                       r_rxready, r_crc_ok, r_aa_timeout, r_overflow;
  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;

  logic                 w_bit, w_match, w_tmo, w_dbit, w_crc_fb;
  logic [SR_W-1:0]      w_sr_nxt;
  logic [TIMEOUT_W-1:0] w_tcnt_nxt;
  logic [7:0]           w_byte_nxt;
  logic [23:0]          w_cmp_nxt, w_crc_nxt;
  logic [6:0]           w_wlfsr_nxt;
  logic [5:0]           w_len;
  logic                 w_byte_done, w_last_byte, w_crc_done, w_full, w_empty, w_wr, w_rd;
  logic                 w_arm, w_srch, w_hit, w_tmo_evt, w_data_bit, w_crc_bit, w_fin;

  assign w_bit       = bus.en & bus.rx_valid;
  assign w_sr_nxt    = {r_sr, bus.rx};
  assign w_tcnt_nxt  = r_tcnt + 1'b1;
  assign w_tmo       = (bus.timeout != '0) && (w_tcnt_nxt == bus.timeout);
`ifdef RX_PREAMBLE_CHK_EN
  assign w_match     = (w_sr_nxt == {(bus.aa[31] ? `PREAMBLE_MSB1 : `PREAMBLE_MSB0), bus.aa});
`else
  assign w_match     = (w_sr_nxt == bus.aa);
`endif
  assign w_dbit      = bus.rx ^ r_wlfsr[6];
  assign w_wlfsr_nxt = {r_wlfsr[5:4], r_wlfsr[3] ^ r_wlfsr[6], r_wlfsr[2:0], r_wlfsr[6]};
  assign w_byte_nxt  = {r_byte, w_dbit};
  assign w_cmp_nxt   = {r_cmp, w_dbit};
  assign w_crc_fb    = r_crc[23] ^ w_dbit;
  assign w_crc_nxt   = {r_crc[22:0], 1'b0} ^ (w_crc_fb ? 24'h00065B : 24'h000000);
  assign w_len       = (bus.rx_len == 6'd0) ? 6'd1 : bus.rx_len;
  assign w_byte_done = (r_bitcnt == 5'd7);
  assign w_last_byte = ((r_bytecnt + 6'd1) == w_len);
  assign w_crc_done  = (r_bitcnt == 5'd23);
  assign w_full      = r_count[FIFO_DEPTH_LOG2];
  assign w_empty     = (r_count == '0);
  assign w_wr        = w_data_bit & w_byte_done & ~w_full;
  assign w_rd        = bus.rd_en & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst)         r_state <= IDLE;
    else if (bus.en) r_state <= w_state_nxt;
  end

  // A registered rxstart re-arms from any state, aborting the packet in flight.
  always_comb begin
    w_state_nxt = r_state;
    if (r_rxstart) begin
      w_state_nxt = SEARCH;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        SEARCH:  if (w_bit && w_match) w_state_nxt = DATA;
                 else if (w_bit && w_tmo) w_state_nxt = IDLE;
        DATA:    if (w_bit && w_byte_done && w_last_byte) w_state_nxt = CRC;
        CRC:     if (w_bit && w_crc_done) w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_arm      = r_rxstart;
    w_srch     = 1'b0;
    w_hit      = 1'b0;
    w_tmo_evt  = 1'b0;
    w_data_bit = 1'b0;
    w_crc_bit  = 1'b0;
    w_fin      = 1'b0;
    if (!r_rxstart) begin
      case (r_state)
        SEARCH: begin
          w_srch    = w_bit;
          w_hit     = w_bit & w_match;
          w_tmo_evt = w_bit & ~w_match & w_tmo;
        end
        DATA:    w_data_bit = w_bit;
        CRC:     w_crc_bit  = w_bit;
        DONE:    w_fin      = 1'b1;
        default: w_fin      = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxstart <= 1'b0;  r_sr <= '0;        r_tcnt <= '0;     r_wlfsr <= '0;
      r_crc <= '0;        r_cmp <= '0;       r_byte <= '0;     r_bitcnt <= '0;
      r_bytecnt <= '0;    r_rxready <= 1'b1; r_crc_ok <= 1'b0;
      r_aa_timeout <= 1'b0;                  r_overflow <= 1'b0;
    end else if (bus.en) begin
      r_rxstart <= bus.rxstart;
      if (w_arm) begin
        r_rxready <= 1'b0;  r_crc_ok <= 1'b0;  r_aa_timeout <= 1'b0;  r_overflow <= 1'b0;
        r_tcnt <= '0;       r_sr <= '0;        r_bitcnt <= '0;        r_bytecnt <= '0;
      end
      if (w_srch) begin
        r_sr   <= w_sr_nxt[SR_W-2:0];
        r_tcnt <= w_tcnt_nxt;
      end
      if (w_hit) begin
        r_wlfsr   <= {1'b1, bus.ch_idx};
        r_crc     <= CRC_INIT;
        r_bitcnt  <= '0;
        r_bytecnt <= '0;
      end
      if (w_tmo_evt) begin
        r_aa_timeout <= 1'b1;
        r_rxready    <= 1'b1;
      end
      if (w_data_bit | w_crc_bit) r_wlfsr <= w_wlfsr_nxt;
      if (w_data_bit) begin
        r_byte   <= w_byte_nxt[6:0];
        r_crc    <= w_crc_nxt;
        r_bitcnt <= w_byte_done ? 5'd0 : r_bitcnt + 5'd1;
        if (w_byte_done) begin
          r_bytecnt <= r_bytecnt + 6'd1;
          if (w_full) r_overflow <= 1'b1;
        end
      end
      if (w_crc_bit) begin
        r_cmp    <= w_cmp_nxt[22:0];
        r_bitcnt <= r_bitcnt + 5'd1;
        if (w_crc_done) r_crc_ok <= (w_cmp_nxt == r_crc);
      end
      if (w_fin) r_rxready <= 1'b1;
    end
  end

  // Flush on arm takes priority over any read issued in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;  r_rptr <= '0;  r_count <= '0;
    end else if (bus.en) begin
      if (w_arm) begin
        r_wptr <= '0;  r_rptr <= '0;  r_count <= '0;
      end else begin
        if (w_wr) r_wptr <= r_wptr + 1'b1;
        if (w_rd) r_rptr <= r_rptr + 1'b1;
        case ({w_wr, w_rd})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.en && w_wr) r_mem[r_wptr] <= w_byte_nxt;
  end

  assign bus.rxready    = r_rxready;
  assign bus.crc_ok     = r_crc_ok;
  assign bus.aa_timeout = r_aa_timeout;
  assign bus.overflow   = r_overflow;
  assign bus.empty      = w_empty;
  assign bus.rxdata_out = w_empty ? 8'h00 : r_mem[r_rptr];
endmodule

// File: tb/tb_rx_framer.sv
// Directed bench for rx_framer: whitened, CRC-protected packets built by a bench model, payload scoreboard.
`ifndef PREAMBLE_MSB1
`define PREAMBLE_MSB1 8'hAA
`endif
`ifndef PREAMBLE_MSB0
`define PREAMBLE_MSB0 8'h55
`endif

module tb_rx_framer;
  localparam logic [23:0] CRC_PRESET = 24'h555555;
  localparam logic [31:0] AA_NOM     = 32'h8E89BED6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] pl [40];
  logic [7:0] exp_q [$];
  logic       bits  [$];

  rx_framer_if #(.TIMEOUT_W(16)) bus ();
  rx_framer #(.FIFO_DEPTH_LOG2(2), .TIMEOUT_W(16), .CRC_INIT(CRC_PRESET)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.rx       = b;
    bus.rx_valid = 1'b1;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic arm();
    @(negedge clk); bus.rx_valid = 1'b0; bus.rxstart = 1'b1;
    @(negedge clk); bus.rxstart = 1'b0;
    @(negedge clk);
  endtask

  // Builds preamble, access address, whitened payload and whitened CRC into the bit queue.
  task automatic build_pkt(input logic [7:0] pre, input logic [31:0] a, input logic [5:0] ch,
                           input int n, input int flip, input int push_max);
    logic [6:0]  w;
    logic [23:0] c;
    logic [7:0]  b;
    logic        fb;
    bits.delete();
    for (int i = 7; i >= 0; i--)  bits.push_back(pre[i]);
    for (int i = 31; i >= 0; i--) bits.push_back(a[i]);
    w = {1'b1, ch};
    c = CRC_PRESET;
    for (int k = 0; k < n; k++) begin
      b = pl[k];
      for (int i = 7; i >= 0; i--) begin
        fb = c[23] ^ b[i];
        c  = {c[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h0);
      end
      if (flip >= k * 8 && flip < k * 8 + 8) b[7 - (flip - k * 8)] = ~b[7 - (flip - k * 8)];
      if (k < push_max) exp_q.push_back(b);
      for (int i = 7; i >= 0; i--) begin
        bits.push_back(b[i] ^ w[6]);
        w = {w[5:4], w[3] ^ w[6], w[2:0], w[6]};
      end
    end
    for (int i = 23; i >= 0; i--) begin
      bits.push_back(c[i] ^ w[6]);
      w = {w[5:4], w[3] ^ w[6], w[2:0], w[6]};
    end
  endtask

  task automatic play(input int gap, input int nbits);
    int n;
    n = (nbits < 0) ? bits.size() : nbits;
    for (int i = 0; i < n; i++) begin
      send_bit(bits.pop_front());
      if (gap != 0) idle_cyc();
    end
  endtask

  task automatic drain(input string tag);
    int          guard;
    logic [31:0] e;
    guard = 0;
    while (bus.empty === 1'b0 && guard < 70) begin
      e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h100;
      check(tag, 32'(bus.rxdata_out), e);
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      guard++;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    bus.en = 1'b1;  bus.rx = 1'b0;  bus.rx_valid = 1'b0;  bus.rxstart = 1'b0;
    bus.ch_idx = 6'd37;  bus.aa = AA_NOM;  bus.rx_len = 6'd4;  bus.timeout = '0;
    bus.rd_en = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_rxready", bus.rxready, 1);
    check("rst_crc_ok", bus.crc_ok, 0);
    check("rst_aa_timeout", bus.aa_timeout, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_rxdata", bus.rxdata_out, 0);
    rst = 1'b0;

    // Nominal packet
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    arm();
    check("nom_armed_rdy", bus.rxready, 0);
    build_pkt(`PREAMBLE_MSB1, AA_NOM, 6'd37, 4, -1, 4);
    play(0, -1);
    idle_cyc();
    check("nom_rdy_1cyc", bus.rxready, 0);
    @(negedge clk);
    check("nom_rdy_2cyc", bus.rxready, 1);
    check("nom_crc_ok", bus.crc_ok, 1);
    check("nom_overflow", bus.overflow, 0);
    drain("nom_byte");

    // Corrupted payload bit
    arm();
    build_pkt(`PREAMBLE_MSB1, AA_NOM, 6'd37, 4, 13, 4);
    play(0, -1);
    idle_cyc();
    @(negedge clk);
    check("bad_rdy", bus.rxready, 1);
    check("bad_crc_ok", bus.crc_ok, 0);
    drain("bad_byte");

    // Address search timeout
    bus.aa = 32'hFFFFFFFF;
    bus.timeout = 16'd100;
    arm();
    for (int i = 0; i < 99; i++) send_bit((i % 16 == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
    idle_cyc();
    check("tmo_99_flag", bus.aa_timeout, 0);
    check("tmo_99_rdy", bus.rxready, 0);
    send_bit(1'b0);
    idle_cyc();
    check("tmo_100_flag", bus.aa_timeout, 1);
    check("tmo_100_rdy", bus.rxready, 1);
    check("tmo_empty", bus.empty, 1);
    bus.timeout = '0;
    bus.aa = AA_NOM;

    // Overflow: 6 bytes into a 4-entry FIFO, no reads
    for (int k = 0; k < 6; k++) pl[k] = 8'hA0 + 8'(k * 17);
    bus.rx_len = 6'd6;
    arm();
    build_pkt(`PREAMBLE_MSB1, AA_NOM, 6'd37, 6, -1, 4);
    play(0, -1);
    idle_cyc();
    @(negedge clk);
    check("ovf_flag", bus.overflow, 1);
    check("ovf_crc_ok", bus.crc_ok, 1);
    drain("ovf_byte");

    // Gapped stream aborted by rxstart after 2 bytes, then a full packet
    pl[0] = 8'hC3; pl[1] = 8'h3C; pl[2] = 8'h5A; pl[3] = 8'hA5;
    bus.rx_len = 6'd4;
    arm();
    build_pkt(`PREAMBLE_MSB1, AA_NOM, 6'd37, 4, -1, 0);
    play(1, 56);
    check("mid_has_data", bus.empty, 0);
    arm();
    check("mid_flushed", bus.empty, 1);
    check("mid_crc_cleared", bus.crc_ok, 0);
    pl[0] = 8'h11; pl[1] = 8'hEE; pl[2] = 8'h00; pl[3] = 8'hFF;
    build_pkt(`PREAMBLE_MSB1, AA_NOM, 6'd37, 4, -1, 4);
    play(1, -1);
    repeat (2) @(negedge clk);
    check("mid_crc_ok", bus.crc_ok, 1);
    check("mid_rdy", bus.rxready, 1);
    drain("mid_byte");

    // Reset in the middle of DATA
    arm();
    build_pkt(`PREAMBLE_MSB1, AA_NOM, 6'd37, 4, -1, 1);
    play(0, 52);
    idle_cyc();
    check("rd_pre_empty", bus.empty, 0);
    check("rd_pre_byte", bus.rxdata_out, 32'(exp_q.pop_front()));
    check("rd_pre_rdy", bus.rxready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rd_rxready", bus.rxready, 1);
    check("rd_crc_ok", bus.crc_ok, 0);
    check("rd_aa_timeout", bus.aa_timeout, 0);
    check("rd_overflow", bus.overflow, 0);
    check("rd_empty", bus.empty, 1);
    check("rd_rxdata", bus.rxdata_out, 0);
    play(0, -1);
    idle_cyc();
    repeat (2) @(negedge clk);
    check("rd_idle_empty", bus.empty, 1);
    check("rd_idle_rdy", bus.rxready, 1);

`ifdef RX_PREAMBLE_CHK_EN
    // Wrong preamble ahead of a correct access address
    arm();
    build_pkt(`PREAMBLE_MSB0, AA_NOM, 6'd37, 4, -1, 0);
    play(0, -1);
    idle_cyc();
    repeat (2) @(negedge clk);
    check("pre_no_detect_empty", bus.empty, 1);
    check("pre_no_detect_rdy", bus.rxready, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_framer.md
Name: rx_framer

Overview:
- Receive-side counterpart of the serial packet transmitter in the TXRX block.
- Takes the demodulated serial bit stream with its bit qualifier, searches for the programmed 32-bit access address, dewhitens the payload and the 24-bit CRC, checks the CRC, and pushes payload bytes into an output FIFO for the CPU.
- Sits between the demodulator and the TXRX register/FIFO interface.

Parameters:
- FIFO_DEPTH_LOG2, 6, log2 depth of the output byte FIFO (64 entries).
- TIMEOUT_W, 16, width of the address-search bit counter.
- CRC_INIT, 24'h555555, CRC LFSR preset value; must match the transmitter CRC preset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  global clock enable; all state frozen when 0
- rx  in  1  serial input bit
- rx_valid  in  1  qualifies rx; exactly one bit is consumed per cycle with en&rx_valid
- rxstart  in  1  arm or restart reception
- rxready  out  1  1 = idle, or last packet finished
- ch_idx  in  `CH_IDX_W  channel index for the dewhitening seed
- aa  in  32  expected access address
- rx_len  in  6  payload byte count, 1..39
- timeout  in  TIMEOUT_W  maximum bits to search for aa; 0 = no limit
- rxdata_out  out  8  FIFO head byte
- rd_en  in  1  pop FIFO head
- empty  out  1  FIFO empty
- crc_ok  out  1  CRC result of the last packet
- aa_timeout  out  1  last search expired without a match
- overflow  out  1  a byte was dropped because the FIFO was full

Behaviour:
- Reset values: rxready=1, crc_ok=0, aa_timeout=0, overflow=0, empty=1, rxdata_out=0, state=IDLE.
- Bit order: every field is received MSB first. The access address arrives as aa[31:24] first.
- States:
  - IDLE
  - SEARCH
  - DATA
  - CRC
  - DONE
- IDLE:
  - rxstart=1 (registered one cycle, as on the transmit side) goes to SEARCH.
  - On that transition: rxready<=0, crc_ok<=0, aa_timeout<=0, overflow<=0, FIFO flushed, bit counter cleared.
- SEARCH:
  - Each qualified bit shifts into a 32-bit raw shift register and increments the bit counter.
  - Match (shift register == aa, including the bit just shifted in) goes to DATA.
  - On match: dewhitener LFSR loaded with {1'b1, ch_idx}, CRC LFSR loaded with CRC_INIT, byte/bit counters cleared.
  - If timeout!=0 and the counter reaches timeout without a match: aa_timeout<=1, rxready<=1, go to IDLE.
- Dewhitening:
  - 7-bit LFSR, polynomial x^7+x^4+1, identical to the transmit whitener.
  - Advances once per qualified bit in DATA and CRC only.
  - Dewhitened bit = rx XOR LFSR output.
- DATA:
  - Dewhitened bits feed the CRC LFSR (polynomial 0x00065B) and an 8-bit assembler.
  - On the 8th bit, the byte is written to the FIFO in the same cycle.
  - If the FIFO is full, the byte is dropped and overflow<=1 (sticky until the next rxstart).
  - After rx_len bytes, go to CRC.
  - rx_len=0 is treated as 1.
- CRC:
  - 24 dewhitened bits are shifted into a compare register; the CRC LFSR is frozen.
  - After the 24th bit: crc_ok <= (compare == CRC LFSR), then go to DONE.
- DONE:
  - One cycle: rxready<=1, then go to IDLE.
  - rxready and crc_ok are therefore valid together 2 cycles after the last CRC bit is qualified.
- FIFO:
  - Synchronous, first-word-fall-through; rxdata_out is valid whenever empty=0.
  - Simultaneous write and rd_en on a non-empty FIFO: both happen, and the count is unchanged.
  - rd_en while empty is ignored.
  - rd_en is honoured in every state, so the CPU may drain the FIFO during reception.
- rxstart outside IDLE: the current packet is aborted and re-armed exactly as from IDLE. Partial bytes are discarded and crc_ok=0.
- rx_valid=0: counters and LFSRs hold their values.
- en=0: the whole block is frozen; rd_en is ignored.
- rst is synchronous and may be asserted in any state; it returns every register to its reset value on the next clock edge.

Optional Feature:
- Macro: RX_PREAMBLE_CHK_EN.
- When defined:
  - The search register is 40 bits wide.
  - A match requires {preamble, aa}, where preamble = aa[31] ? `PREAMBLE_MSB1 : `PREAMBLE_MSB0.
  - This reduces false address detection.
- When undefined: the 32-bit aa-only match described above applies, and the preamble bits are just shifted through.

Test Plan:
- Nominal packet: aa=32'h8E89BED6, ch_idx=37, rx_len=4, payload 01 02 03 04 with correct CRC, whitened stream driven.
  - FIFO holds 01 02 03 04.
  - crc_ok=1 and rxready=1, two cycles after the last bit.
- Corrupted packet: as above, with one payload bit flipped.
  - FIFO holds the corrupted byte.
  - crc_ok=0, rxready=1.
- Timeout: timeout=100, random bits that never match aa.
  - aa_timeout=1 and rxready=1 after exactly 100 qualified bits.
  - FIFO empty.
- Overflow: FIFO_DEPTH_LOG2=2, rx_len=6, no reads.
  - First 4 bytes retained.
  - overflow=1, crc_ok still computed correctly over all 6 bytes.
- Mid-packet rxstart and gaps: rx_valid toggling 1/0, rxstart asserted after 2 payload bytes, followed by a full valid packet.
  - FIFO flushed at the rxstart.
  - Only the second packet's bytes are present, and crc_ok=1.
- Reset mid-DATA: rst pulsed in DATA.
  - All outputs return to their reset values on the next edge.
  - Block idle with rxready=1.
  - With RX_PREAMBLE_CHK_EN defined, an aa preceded by a wrong preamble is not detected.
